fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core.
- Owns the PC and runs a single-outstanding request/response handshake to instruction memory.
- Presents the fetched instruction and its PC to decode.
- Honours `stall` from the load-use hazard unit and the `branch_taken` redirect from execute. Wrong-path fetches are discarded, including responses still in flight.

---
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Owns the PC and runs a single-outstanding req/gnt/rvalid handshake to
// instruction memory. Fetched words are presented to decode through the IF/ID
// register. A one-entry skid buffer catches a response that lands while
// decode is stalled. Redirects from execute flush IF/ID and the skid buffer.
// A request that is already in flight is dropped when its response returns.
//
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched and
// perf_stall_cycles counters and their output ports.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   stall                - freeze IF/ID (hazard unit)
//   branch_taken/target  - redirect and flush from execute
//   imem_req/addr/gnt    - request channel (addr = pc, held until granted)
//   imem_rvalid/rdata    - in-order response channel
//   if_id_pc/inst/valid  - IF/ID register contents (valid=0 is a bubble)
//   perf_*               - perf counters (FETCH_PERF_EN only)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, req_pc;
    logic        skid_full;
    logic [31:0] skid_inst, skid_pc;
    logic        fire;      // request accepted this cycle
    logic        resp_ok;   // right-path response usable this cycle
    logic        unused_tgt_lsb;

    // Targets are word-aligned; the low bits are discarded.
    assign unused_tgt_lsb = ^branch_target[1:0];

    assign imem_req  = (state == REQ) && !skid_full && !reset;
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;
    assign resp_ok   = (state == WAIT) && imem_rvalid && !branch_taken;

    always_comb begin
        state_next = state;
        case (state)
            REQ:  if (fire) state_next = branch_taken ? DROP : WAIT;
            // A flush while waiting turns the in-flight response into garbage.
            // If the response arrives in the flush cycle, it is discarded here.
            WAIT: if (imem_rvalid)       state_next = REQ;
                  else if (branch_taken) state_next = DROP;
            // The dropped response retires the only outstanding request.
            // A redirect in that same cycle has nothing more to drop.
            DROP: if (imem_rvalid) state_next = REQ;
            default: state_next = REQ;
        endcase
    end

    always_comb begin
        pc_next = pc;
        if (branch_taken)
            pc_next = {branch_target[31:2], 2'b00};
        else if (fire)
            pc_next = pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            pc          <= PC0;
            req_pc      <= PC0;
            skid_full   <= 1'b0;
            skid_pc     <= 32'd0;
            skid_inst   <= NOP;
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'd0;
            if_id_inst  <= NOP;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (fire)
                req_pc <= pc;

            if (branch_taken) begin
                if_id_valid <= 1'b0;
                skid_full   <= 1'b0;
            end else if (!stall) begin
                // The skid buffer is older than any new response. It cannot
                // coexist with WAIT, because no request issues while it is full.
                skid_full <= 1'b0;
                if (skid_full) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= skid_pc;
                    if_id_inst  <= skid_inst;
                end else if (resp_ok) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= req_pc;
                    if_id_inst  <= imem_rdata;
                end else begin
                    if_id_valid <= 1'b0;
                end
            end else if (resp_ok) begin
                skid_full <= 1'b1;
                skid_pc   <= req_pc;
                skid_inst <= imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic load_valid;
    assign load_valid = !branch_taken && !stall && (skid_full || resp_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (load_valid)
                perf_fetched <= perf_fetched + 32'd1;
            if (stall && !branch_taken)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A lockstep cycle task drives a
// randomised memory responder and checks the architectural fetch stream:
// every valid IF/ID load must be the next sequential PC (or the branch
// target after a redirect), carrying that address's memory word.
module tb_fetch_stage;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc, if_id_inst;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall_cycles;
`endif

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    int          gnt_mode = 0;          // 0: always grant, 1: random, 2: never
    int          lat_min = 1, lat_max = 1;
    bit          pend = 0;
    logic [31:0] pend_addr = 0;
    int          pend_cnt = 0;
    logic [31:0] exp_pc = RPC;
    int          n_fetched = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: sample just before the edge, then check the new
    // IF/ID state and compute the responder's drive for the next cycle.
    task automatic tick();
        logic s_reset, s_stall, s_br, s_req, s_gnt, s_rv, pv;
        logic [31:0] s_tgt, s_addr, ppc, pinst;
        #2;
        s_reset = reset; s_stall = stall; s_br = branch_taken; s_tgt = branch_target;
        s_req = imem_req; s_gnt = imem_gnt; s_rv = imem_rvalid; s_addr = imem_addr;
        pv = if_id_valid; ppc = if_id_pc; pinst = if_id_inst;
        @(posedge clk); #1;

        if (s_reset) begin
            total++;
            if (if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_inst !== NOP) begin
                bad++;
                $display("FAIL reset_state: got v=%b pc=%h inst=%h want v=0 pc=0 inst=%h",
                         if_id_valid, if_id_pc, if_id_inst, NOP);
            end
            exp_pc = RPC;
        end else if (s_br) begin
            total++;
            if (if_id_valid !== 1'b0) begin
                bad++; $display("FAIL flush_bubble: got v=%b want 0", if_id_valid);
            end
            exp_pc = {s_tgt[31:2], 2'b00};
        end else if (s_stall) begin
            total++;
            if (if_id_valid !== pv || if_id_pc !== ppc || if_id_inst !== pinst) begin
                bad++;
                $display("FAIL stall_hold: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h",
                         if_id_valid, if_id_pc, if_id_inst, pv, ppc, pinst);
            end
        end else if (if_id_valid === 1'b1) begin
            total++;
            if (if_id_pc !== exp_pc || if_id_inst !== mem_word(exp_pc)) begin
                bad++;
                $display("FAIL stream: got pc=%h inst=%h want pc=%h inst=%h",
                         if_id_pc, if_id_inst, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            n_fetched++;
        end

        if (!s_reset && !s_br && s_req && !s_gnt) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== s_addr) begin
                bad++;
                $display("FAIL req_hold: got req=%b addr=%h want req=1 addr=%h",
                         imem_req, imem_addr, s_addr);
            end
        end
        if (!s_reset && s_req && s_gnt) begin
            total++;
            if (imem_req !== 1'b0) begin
                bad++; $display("FAIL back_to_back: got req=%b want 0", imem_req);
            end
        end

        if (s_reset) pend = 0;
        else begin
            if (s_rv) pend = 0;
            if (s_req && s_gnt) begin
                pend = 1; pend_addr = s_addr;
                pend_cnt = int'($urandom_range(lat_max, lat_min)) - 1;
            end else if (pend && pend_cnt > 0) pend_cnt--;
        end
        imem_rvalid = pend && (pend_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(pend_addr) : $urandom;
        case (gnt_mode)
            0:       imem_gnt = 1'b1;
            1:       imem_gnt = 1'($urandom_range(1, 0));
            default: imem_gnt = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        tick(); tick();
        reset = 0; n_fetched = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
        imem_gnt = 1; imem_rvalid = 0; imem_rdata = 0;
        for (int i = 0; i < 3; i++) begin
            #1; total++;
            if (imem_req !== 1'b0) begin
                bad++; $display("FAIL reset_req: got %b want 0", imem_req);
            end
            tick();
        end
        total++;
        if (if_id_valid !== 1'b0 || if_id_pc !== 32'd0 || if_id_inst !== NOP) begin
            bad++; $display("FAIL reset_ifid: got v=%b pc=%h inst=%h", if_id_valid, if_id_pc, if_id_inst);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (perf_fetched !== 32'd0 || perf_stall_cycles !== 32'd0) begin
            bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_stall_cycles);
        end
`endif
        reset = 0; #1; total++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            bad++; $display("FAIL first_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
        end
        tick();
    endtask

    task automatic test_zero_wait();
        logic        er, ev;
        logic [31:0] ea, ep;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            #1;
            er = (k % 2 == 0); ea = RPC + 32'(2 * k);
            ev = (k >= 2) && (k % 2 == 0); ep = RPC + 32'(2 * (k - 2));
            total++;
            if (imem_req !== er || (er && imem_addr !== ea)) begin
                bad++; $display("FAIL zw_req k=%0d: got req=%b addr=%h want req=%b addr=%h", k, imem_req, imem_addr, er, ea);
            end
            total++;
            if (if_id_valid !== ev || (ev && (if_id_pc !== ep || if_id_inst !== mem_word(ep)))) begin
                bad++; $display("FAIL zw_ifid k=%0d: got v=%b pc=%h want v=%b pc=%h", k, if_id_valid, if_id_pc, ev, ep);
            end
            tick();
        end
    endtask

    task automatic test_stall_skid();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            stall = (k >= 2 && k <= 4);
            #1;
            if (k >= 3 && k <= 5) begin
                total++;
                if (if_id_valid !== 1'b1 || if_id_pc !== RPC) begin
                    bad++; $display("FAIL skid_hold k=%0d: got v=%b pc=%h want 1 %h", k, if_id_valid, if_id_pc, RPC);
                end
            end
            if (k == 4 || k == 5) begin
                total++;
                if (imem_req !== 1'b0) begin
                    bad++; $display("FAIL skid_noreq k=%0d: got req=%b want 0", k, imem_req);
                end
            end
            if (k == 6) begin
                total++;
                if (if_id_valid !== 1'b1 || if_id_pc !== RPC + 4 || if_id_inst !== mem_word(RPC + 4)) begin
                    bad++; $display("FAIL skid_load: got v=%b pc=%h inst=%h want pc=%h", if_id_valid, if_id_pc, if_id_inst, RPC + 4);
                end
                total++;
                if (imem_req !== 1'b1 || imem_addr !== RPC + 8) begin
                    bad++; $display("FAIL skid_next: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC + 8);
                end
            end
            tick();
        end
        stall = 0;
    endtask

    task automatic test_branch_wait();
        do_reset();
        lat_min = 4; lat_max = 4;
        for (int k = 0; k < 8; k++) begin
            branch_taken = (k == 1); branch_target = 32'h0000_0202;
            #1;
            if (k >= 2 && k <= 6) begin
                total++;
                if (if_id_valid !== 1'b0) begin
                    bad++; $display("FAIL bw_bubble k=%0d: got v=%b want 0", k, if_id_valid);
                end
            end
            if (k >= 2 && k <= 4) begin
                total++;
                if (imem_req !== 1'b0) begin
                    bad++; $display("FAIL bw_noreq k=%0d: got req=%b want 0", k, imem_req);
                end
            end
            if (k == 5) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
                    bad++; $display("FAIL bw_target: got req=%b addr=%h want 1 200", imem_req, imem_addr);
                end
            end
            if (k == 7) begin
                total++;
                if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_inst !== mem_word(32'h200)) begin
                    bad++; $display("FAIL bw_load: got v=%b pc=%h inst=%h want pc=200", if_id_valid, if_id_pc, if_id_inst);
                end
            end
            tick();
            if (k == 1) begin lat_min = 1; lat_max = 1; end
        end
        branch_taken = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            stall = (k == 1); branch_taken = (k == 1); branch_target = 32'h0000_0300;
            #1;
            if (k == 2 || k == 3) begin
                total++;
                if (if_id_valid !== 1'b0) begin
                    bad++; $display("FAIL sim_bubble k=%0d: got v=%b want 0", k, if_id_valid);
                end
            end
            if (k == 2) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
                    bad++; $display("FAIL sim_target: got req=%b addr=%h want 1 300", imem_req, imem_addr);
                end
            end
            if (k == 4) begin
                total++;
                if (if_id_valid !== 1'b1 || if_id_pc !== 32'h300 || if_id_inst !== mem_word(32'h300)) begin
                    bad++; $display("FAIL sim_load: got v=%b pc=%h want pc=300", if_id_valid, if_id_pc);
                end
            end
            tick();
        end
        stall = 0; branch_taken = 0;
    endtask

    task automatic test_granted_flush();
        do_reset();
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 6; k++) begin
            branch_taken = (k == 0); branch_target = 32'h0000_0400;
            #1;
            if (k >= 1 && k <= 4) begin
                total++;
                if (if_id_valid !== 1'b0) begin
                    bad++; $display("FAIL gf_bubble k=%0d: got v=%b want 0", k, if_id_valid);
                end
            end
            if (k == 1 || k == 2) begin
                total++;
                if (imem_req !== 1'b0) begin
                    bad++; $display("FAIL gf_drop k=%0d: got req=%b want 0", k, imem_req);
                end
            end
            if (k == 3) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
                    bad++; $display("FAIL gf_target: got req=%b addr=%h want 1 400", imem_req, imem_addr);
                end
            end
            if (k == 5) begin
                total++;
                if (if_id_valid !== 1'b1 || if_id_pc !== 32'h400 || if_id_inst !== mem_word(32'h400)) begin
                    bad++; $display("FAIL gf_load: got v=%b pc=%h want pc=400", if_id_valid, if_id_pc);
                end
            end
            tick();
            if (k == 0) begin lat_min = 1; lat_max = 1; end
        end
        branch_taken = 0;
    endtask

    task automatic test_reset_perf();
        do_reset();
        lat_min = 2; lat_max = 2;
        tick();                          // 0x100 granted, now WAIT
        reset = 1; #1; total++;
        if (imem_req !== 1'b0) begin
            bad++; $display("FAIL rst_mid_req: got %b want 0", imem_req);
        end
        tick();
        reset = 0; lat_min = 1; lat_max = 1;
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;   // stale response
        #1; total++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            bad++; $display("FAIL rst_restart: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
        end
        tick();
        imem_gnt = 1; #1; total++;
        if (if_id_valid !== 1'b0 || imem_addr !== RPC) begin
            bad++; $display("FAIL rst_stale: got v=%b addr=%h want v=0 addr=%h", if_id_valid, imem_addr, RPC);
        end
        n_fetched = 0;
        for (int c = 0; c < 200 && n_fetched < 10; c++) begin
            stall = (c == 3 || c == 4 || c == 9 || c == 14);
            tick();
        end
        stall = 0;
        total++;
        if (n_fetched != 10) begin
            bad++; $display("FAIL perf_run: loads=%0d want 10 within budget", n_fetched);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (perf_fetched !== 32'd10) begin
            bad++; $display("FAIL perf_fetched: got %0d want 10", perf_fetched);
        end
        total++;
        if (perf_stall_cycles !== 32'd4) begin
            bad++; $display("FAIL perf_stall: got %0d want 4", perf_stall_cycles);
        end
`endif
    endtask

    task automatic test_random();
        int start;
        do_reset();
        gnt_mode = 1; lat_min = 1; lat_max = 4;
        start = n_fetched;
        for (int c = 0; c < 1500; c++) begin
            reset        = ($urandom_range(99, 0) == 0);
            stall        = ($urandom_range(3, 0) == 0);
            branch_taken = ($urandom_range(15, 0) == 0);
            branch_target = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : ($urandom & 32'h0000_0FFF);
            tick();
        end
        reset = 0; stall = 0; branch_taken = 0;
        total++;
        if (n_fetched - start < 50) begin
            bad++; $display("FAIL rand_progress: loads=%0d want >= 50", n_fetched - start);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_branch_wait();
        test_simultaneous();
        test_granted_flush();
        test_reset_perf();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
